// File: rtl/game_pkg.sv
// Shared definitions for the game state controller slice: state encoding,
// default game constants and a constant-time decimal-to-BCD helper.
// Build option: GAME_STATE_SCORE_BCD_EN selects a packed-BCD score.
package game_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_PLAY      = 3'd1,
      ST_DYING     = 3'd2,
      ST_GAME_OVER = 3'd3,
      ST_WIN       = 3'd4
   } game_state_t;

   localparam int DEF_LIVES        = 3;
   localparam int DEF_FREEZE_TICKS = 120;
   localparam int DEF_SCORE_STEP   = 10;
   localparam int SCORE_W          = 16;

   // Decimal value to 4 packed BCD digits; values above 9999 clamp to 9999.
   function automatic logic [15:0] to_bcd(input int unsigned v);
      logic [15:0] r;
      int unsigned t;
      r = '0;
      t = (v > 32'd9999) ? 32'd9999 : v;
      for (int i = 0; i < 4; i++) begin
         r[i*4 +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

endpackage

// File: rtl/game_state_ctrl_if.sv
// Frame-level control bus between game logic and the game state controller.
// master = game logic side (drives events), slave = controller.
interface game_state_ctrl_if;
   import game_pkg::*;

   logic               tick;
   logic               start_btn;
   logic               pacman_is_dead;
   logic               food_eaten;
   logic               freeze;
   logic               game_restart;
   logic [1:0]         lives;
   logic [SCORE_W-1:0] score;
   logic [2:0]         state;

   modport master (
      output tick, start_btn, pacman_is_dead, food_eaten,
      input  freeze, game_restart, lives, score, state
   );

   modport slave (
      input  tick, start_btn, pacman_is_dead, food_eaten,
      output freeze, game_restart, lives, score, state
   );

endinterface

// File: rtl/score_accum.sv
// Saturating score adder. Plain binary (saturates at 16'hFFFF) by default;
// with GAME_STATE_SCORE_BCD_EN defined both operands are 4-digit packed BCD
// and the sum saturates at 16'h9999.
module score_accum (
   input  logic [15:0] score_in,
   input  logic [15:0] step,
   output logic [15:0] score_out
);

`ifdef GAME_STATE_SCORE_BCD_EN
   // Digit-serial BCD add; a carry out of the top digit means overflow.
   function automatic logic [15:0] bcd_add_sat(input logic [15:0] a,
                                               input logic [15:0] b);
      logic [15:0] r;
      logic [4:0]  d;
      logic        c;
      r = '0;
      c = 1'b0;
      for (int i = 0; i < 4; i++) begin
         d = {1'b0, a[i*4 +: 4]} + {1'b0, b[i*4 +: 4]} + {4'b0, c};
         if (d > 5'd9) begin
            d = d + 5'd6;
            c = 1'b1;
         end else begin
            c = 1'b0;
         end
         r[i*4 +: 4] = d[3:0];
      end
      return c ? 16'h9999 : r;
   endfunction

   // Combinational BCD accumulate step
   always_comb score_out = bcd_add_sat(score_in, step);
`else
   function automatic logic [15:0] bin_add_sat(input logic [15:0] a,
                                               input logic [15:0] b);
      logic [16:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[16] ? 16'hFFFF : s[15:0];
   endfunction

   // Combinational binary accumulate step
   always_comb score_out = bin_add_sat(score_in, step);
`endif

endmodule

// File: rtl/game_state_ctrl.sv
// Game state controller: IDLE/PLAY/DYING/GAME_OVER/WIN sequencing, lives,
// score and pellet bookkeeping, sprite freeze and restart pulse. All outputs
// are registered. Build option GAME_STATE_SCORE_BCD_EN switches the score to
// 4 packed BCD digits (step given in decimal, converted at elaboration).
module game_state_ctrl
   import game_pkg::*;
#(
   parameter int INIT_LIVES         = DEF_LIVES,
   parameter int DEATH_FREEZE_TICKS = DEF_FREEZE_TICKS,
   parameter int SCORE_PER_FOOD     = DEF_SCORE_STEP,
   parameter int FOOD_TOTAL         = 300
) (
   input logic               clk,
   input logic               rst,
   game_state_ctrl_if.slave  bus
);

   localparam logic [1:0] LIVES_INIT  = 2'(INIT_LIVES);
   localparam logic [7:0] FREEZE_INIT = 8'(DEATH_FREEZE_TICKS);
   localparam logic [9:0] FOOD_LAST   = 10'(FOOD_TOTAL);
`ifdef GAME_STATE_SCORE_BCD_EN
   localparam logic [15:0] SCORE_STEP = to_bcd(SCORE_PER_FOOD);
`else
   localparam logic [15:0] SCORE_STEP = 16'(SCORE_PER_FOOD);
`endif

   game_state_t   state_q;
   logic [1:0]    lives_q;
   logic [15:0]   score_q;
   logic [9:0]    food_cnt_q;
   logic [7:0]    frz_cnt_q;
   logic          dead_prev_q;
   logic          restart_q;
   logic          freeze_q;

   logic [15:0]   score_sum;
   logic [9:0]    food_next;
   logic          death_evt;
   logic          level_done;

   score_accum u_score_accum (
      .score_in  (score_q),
      .step      (SCORE_STEP),
      .score_out (score_sum)
   );

   // A held-high collision counts once: only the rising edge is an event.
   assign death_evt  = bus.pacman_is_dead & ~dead_prev_q;
   assign food_next  = food_cnt_q + 10'd1;
   assign level_done = bus.food_eaten && (food_next == FOOD_LAST);

   // Game FSM with all bookkeeping and outputs registered alongside the state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         lives_q     <= '0;
         score_q     <= '0;
         food_cnt_q  <= '0;
         frz_cnt_q   <= '0;
         dead_prev_q <= 1'b0;
         restart_q   <= 1'b0;
         freeze_q    <= 1'b1;
      end else begin
         dead_prev_q <= bus.pacman_is_dead;
         restart_q   <= 1'b0;
         case (state_q)
            ST_IDLE, ST_GAME_OVER, ST_WIN: begin
               if (bus.start_btn) begin
                  state_q    <= ST_PLAY;
                  freeze_q   <= 1'b0;
                  restart_q  <= 1'b1;
                  lives_q    <= LIVES_INIT;
                  score_q    <= '0;
                  food_cnt_q <= '0;
                  frz_cnt_q  <= '0;
               end
            end
            ST_PLAY: begin
               // Food is booked before a same-cycle death is considered.
               if (bus.food_eaten) begin
                  score_q    <= score_sum;
                  food_cnt_q <= food_next;
               end
               if (level_done) begin
                  state_q  <= ST_WIN;
                  freeze_q <= 1'b1;
               end else if (death_evt) begin
                  freeze_q <= 1'b1;
                  if (lives_q > 2'd1) begin
                     lives_q   <= lives_q - 2'd1;
                     frz_cnt_q <= FREEZE_INIT;
                     state_q   <= ST_DYING;
                  end else begin
                     lives_q <= '0;
                     state_q <= ST_GAME_OVER;
                  end
               end
            end
            ST_DYING: begin
               if (bus.tick) begin
                  frz_cnt_q <= frz_cnt_q - 8'd1;
                  if (frz_cnt_q == 8'd1) begin
                     state_q  <= ST_PLAY;
                     freeze_q <= 1'b0;
                  end
               end
            end
            default: begin
               state_q  <= ST_IDLE;
               freeze_q <= 1'b1;
            end
         endcase
      end
   end

   assign bus.state        = state_q;
   assign bus.lives        = lives_q;
   assign bus.score        = score_q;
   assign bus.freeze       = freeze_q;
   assign bus.game_restart = restart_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Bench for game_state_ctrl: two instances (score step 10 and 60000, four
// pellets per level) driven by the same directed and random stimulus and
// compared every cycle against a rule-level game model.
module tb_game_state_ctrl;

   localparam int FT    = 120;
   localparam int NFOOD = 4;
   localparam int P_IDLE = 0, P_PLAY = 1, P_DYING = 2, P_OVER = 3, P_WIN = 4;
`ifdef GAME_STATE_SCORE_BCD_EN
   localparam logic [31:0] SCORE40  = 32'h0040;
   localparam logic [31:0] SCORE10  = 32'h0010;
   localparam logic [31:0] SCORECAP = 32'h9999;
`else
   localparam logic [31:0] SCORE40  = 32'd40;
   localparam logic [31:0] SCORE10  = 32'd10;
   localparam logic [31:0] SCORECAP = 32'd65535;
`endif

   logic clk = 1'b0;
   logic rst, tick, start_btn, pacman_is_dead, food_eaten;

   always #5 clk = ~clk;

   game_state_ctrl_if ifa ();
   game_state_ctrl_if ifb ();

   assign ifa.tick = tick;             assign ifb.tick = tick;
   assign ifa.start_btn = start_btn;   assign ifb.start_btn = start_btn;
   assign ifa.pacman_is_dead = pacman_is_dead;
   assign ifb.pacman_is_dead = pacman_is_dead;
   assign ifa.food_eaten = food_eaten; assign ifb.food_eaten = food_eaten;

   game_state_ctrl #(.INIT_LIVES(3), .DEATH_FREEZE_TICKS(FT),
                     .SCORE_PER_FOOD(10), .FOOD_TOTAL(NFOOD))
   dut_a (.clk(clk), .rst(rst), .bus(ifa));

   game_state_ctrl #(.INIT_LIVES(3), .DEATH_FREEZE_TICKS(FT),
                     .SCORE_PER_FOOD(60000), .FOOD_TOTAL(NFOOD))
   dut_b (.clk(clk), .rst(rst), .bus(ifb));

   int n_cmp = 0;
   int n_err = 0;

   // Reference game model: one entry per instance
   int m_phase[2], m_lives[2], m_score[2], m_food[2], m_frz[2], m_restart[2];
   int step_pts[2] = '{10, 60000};
   bit m_prev;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic int add_pts(input int s, input int p);
      int cap, inc;
`ifdef GAME_STATE_SCORE_BCD_EN
      cap = 9999;
      inc = (p > 9999) ? 9999 : p;
`else
      cap = 65535;
      inc = p;
`endif
      return (s + inc > cap) ? cap : s + inc;
   endfunction

   function automatic logic [31:0] score_bits(input int pts);
`ifdef GAME_STATE_SCORE_BCD_EN
      return 32'(((pts / 1000) % 10) * 4096 + ((pts / 100) % 10) * 256 +
                 ((pts / 10) % 10) * 16 + pts % 10);
`else
      return 32'(pts);
`endif
   endfunction

   task automatic model_reset();
      m_prev = 1'b0;
      for (int k = 0; k < 2; k++) begin
         m_phase[k] = P_IDLE; m_lives[k] = 0; m_score[k] = 0;
         m_food[k] = 0; m_frz[k] = 0; m_restart[k] = 0;
      end
   endtask

   task automatic model_update();
      bit ev, won;
      ev = pacman_is_dead && !m_prev;
      m_prev = pacman_is_dead;
      for (int k = 0; k < 2; k++) begin
         m_restart[k] = 0;
         won = 1'b0;
         if (m_phase[k] == P_PLAY) begin
            if (food_eaten) begin
               m_score[k] = add_pts(m_score[k], step_pts[k]);
               m_food[k]++;
               won = (m_food[k] == NFOOD);
            end
            if (won) m_phase[k] = P_WIN;
            else if (ev) begin
               if (m_lives[k] > 1) begin
                  m_lives[k]--; m_frz[k] = FT; m_phase[k] = P_DYING;
               end else begin
                  m_lives[k] = 0; m_phase[k] = P_OVER;
               end
            end
         end else if (m_phase[k] == P_DYING) begin
            if (tick) begin
               m_frz[k]--;
               if (m_frz[k] == 0) m_phase[k] = P_PLAY;
            end
         end else if (start_btn) begin
            m_phase[k] = P_PLAY; m_lives[k] = 3; m_score[k] = 0;
            m_food[k] = 0; m_restart[k] = 1;
         end
      end
   endtask

   task automatic check_one(input string tag, input int k, input logic [2:0] st,
                            input logic [1:0] lv, input logic [15:0] sc,
                            input logic fz, input logic gr);
      chk({tag, "/state"},   32'(st), 32'(m_phase[k]));
      chk({tag, "/lives"},   32'(lv), 32'(m_lives[k]));
      chk({tag, "/score"},   32'(sc), score_bits(m_score[k]));
      chk({tag, "/freeze"},  32'(fz), 32'(m_phase[k] != P_PLAY));
      chk({tag, "/restart"}, 32'(gr), 32'(m_restart[k]));
   endtask

   task automatic check_all(input string tag);
      check_one({tag, ".a"}, 0, ifa.state, ifa.lives, ifa.score, ifa.freeze, ifa.game_restart);
      check_one({tag, ".b"}, 1, ifb.state, ifb.lives, ifb.score, ifb.freeze, ifb.game_restart);
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model_update();
      #1;
      check_all(tag);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      model_reset();
      check_all("rst");
      #1;
      rst = 1'b0;
   endtask

   task automatic start_game();
      start_btn = 1'b1;
      step("start");
      start_btn = 1'b0;
      chk("start_restart", 32'(ifa.game_restart), 32'd1);
      chk("start_state",   32'(ifa.state), 32'd1);
      chk("start_lives",   32'(ifa.lives), 32'd3);
      chk("start_score",   32'(ifa.score), 32'd0);
      chk("start_freeze",  32'(ifa.freeze), 32'd0);
      step("start_after");
      chk("restart_1cyc",  32'(ifa.game_restart), 32'd0);
   endtask

   task automatic pulse_food();
      food_eaten = 1'b1;
      step("food");
      food_eaten = 1'b0;
   endtask

   // Death via a 5-cycle held collision, ticks every cycle; returns DYING cycles seen
   task automatic die(output int cnt);
      cnt = 0;
      tick = 1'b1;
      pacman_is_dead = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step("dead_hold");
         if (ifa.state == 3'd2) cnt++;
      end
      pacman_is_dead = 1'b0;
      for (int i = 0; i < 400 && ifa.state == 3'd2; i++) begin
         step("dying");
         if (ifa.state == 3'd2) cnt++;
      end
      tick = 1'b0;
      step("after_death");
   endtask

   initial begin
      int cnt;
      rst = 1'b1; tick = 1'b0; start_btn = 1'b0;
      pacman_is_dead = 1'b0; food_eaten = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      do_reset();
      chk("rst_state",   32'(ifa.state), 32'd0);
      chk("rst_freeze",  32'(ifa.freeze), 32'd1);
      chk("rst_lives",   32'(ifa.lives), 32'd0);
      chk("rst_score",   32'(ifa.score), 32'd0);
      chk("rst_restart", 32'(ifa.game_restart), 32'd0);
      step("idle");

      // Deaths down to game over, then food must be ignored
      start_game();
      pulse_food();
      step("gap");
      die(cnt);
      chk("death1_lives", 32'(ifa.lives), 32'd2);
      chk("death1_dying_cycles", 32'(cnt), 32'(FT));
      chk("death1_back_play", 32'(ifa.state), 32'd1);
      die(cnt);
      chk("death2_lives", 32'(ifa.lives), 32'd1);
      die(cnt);
      chk("death3_lives",  32'(ifa.lives), 32'd0);
      chk("death3_state",  32'(ifa.state), 32'd3);
      chk("death3_freeze", 32'(ifa.freeze), 32'd1);
      pulse_food();
      pulse_food();
      chk("over_food_ignored", 32'(ifa.score), SCORE10);

      // Level completion and saturation
      start_game();
      for (int i = 0; i < NFOOD; i++) begin
         pulse_food();
         if (i == 1) chk("sat_score_b", 32'(ifb.score), SCORECAP);
         step("food_gap");
      end
      chk("win_score_a", 32'(ifa.score), SCORE40);
      chk("win_state",   32'(ifa.state), 32'd4);

      // Last pellet coincident with a death edge: level win wins
      start_game();
      for (int i = 0; i < NFOOD - 1; i++) pulse_food();
      food_eaten = 1'b1;
      pacman_is_dead = 1'b1;
      step("food_and_death");
      food_eaten = 1'b0;
      chk("coinc_state", 32'(ifa.state), 32'd4);
      chk("coinc_lives", 32'(ifa.lives), 32'd3);
      pacman_is_dead = 1'b0;
      step("coinc_after");

      // Reset in the middle of the death freeze
      start_game();
      pacman_is_dead = 1'b1;
      step("die_once");
      pacman_is_dead = 1'b0;
      tick = 1'b1;
      for (int i = 0; i < FT - 50; i++) step("freeze_count");
      tick = 1'b0;
      chk("mid_dying_state", 32'(ifa.state), 32'd2);
      do_reset();
      chk("midrst_state", 32'(ifa.state), 32'd0);
      step("post_rst");
      start_game();

      // Random traffic with occasional asynchronous resets
      for (int i = 0; i < 4000; i++) begin
         tick       = ($urandom_range(0, 1) == 0);
         start_btn  = ($urandom_range(0, 15) == 0);
         food_eaten = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 7) == 0) pacman_is_dead = ~pacman_is_dead;
         if ($urandom_range(0, 599) == 0) do_reset();
         step("rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
